pipelined_divider: RTL

Fully pipelined unsigned restoring divider producing an N-bit quotient and an M-bit remainder, with R quotient bits resolved per pipeline stage. It accepts one operation per cycle under a valid/ready handshake and stalls the whole pipe on output backpressure. A tag field, such as the filter index K, travels alongside each operation. It also flags divide-by-zero and supports a synchronous flush. It replaces chains of single-bit divider cells in the SCNN post-processing path.

---
 rtl/pipelined_divider_if.sv | 39 +++
 rtl/pipelined_divider.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pipelined_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_divider_if
// Purpose  : Operation/result handshake bundle for the pipelined divider.
//            The master side offers operations and consumes results. The
//            slave side is the divider itself.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_divider_if #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int TAG_W = 4
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_dividend;
  logic [M-1:0]     in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_quotient;
  logic [M-1:0]     out_remainder;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;

  // Producer/consumer side
  modport master (
    output flush, in_valid, in_dividend, in_divisor, in_tag, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_tag, out_dz
  );

  // Divider side
  modport slave (
    input  flush, in_valid, in_dividend, in_divisor, in_tag, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_tag, out_dz
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_divider.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_divider
// Purpose  : Fully pipelined unsigned restoring divider. Stage 0 captures the
//            operands. Each of the following N/R stages resolves R quotient
//            bits, MSB first. The whole pipe stalls on output backpressure.
//            A sideband tag and a divide-by-zero flag travel with each op.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_divider #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int R     = 1,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_divider_if.slave bus
);

  localparam int L = N / R;

  // Reject parameter combinations the datapath cannot support
  generate
    if ((N % R) != 0) begin : g_bad_r
      $error("pipelined_divider: R must divide N");
    end
    if (M > N) begin : g_bad_m
      $error("pipelined_divider: M must not exceed N");
    end
  endgenerate

  // One pipeline slot: partial remainder is one bit wider than the divisor
  // so the trial subtraction never overflows.
  typedef struct packed {
    logic             valid;
    logic [M:0]       rem;
    logic [N-1:0]     dvd;
    logic [N-1:0]     quo;
    logic [M-1:0]     dvs;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } stage_t;

  // Slot 0 holds raw operands; slot L holds the finished result.
  stage_t stage_q [0:L];
  stage_t stage_d [0:L];

  logic stall;
  logic accept;

  // Resolve R quotient bits. With a zero divisor the compare always succeeds,
  // so the quotient fills with ones and the remainder ends up holding the
  // low dividend bits. That is exactly the divide-by-zero result.
  function automatic stage_t div_step(input stage_t s);
    stage_t o;
    o = s;
    for (int i = 0; i < R; i++) begin
      o.rem = {o.rem[M-1:0], o.dvd[N-1]};
      o.dvd = o.dvd << 1;
      o.quo = o.quo << 1;
      if (o.rem >= {1'b0, o.dvs}) begin
        o.rem    = o.rem - {1'b0, o.dvs};
        o.quo[0] = 1'b1;
      end
    end
    return o;
  endfunction

  assign stall       = stage_q[L].valid & ~bus.out_ready;
  assign accept      = bus.in_valid & ~stall;
  assign bus.in_ready = ~stall;

  // Next pipe contents: hold everything on stall, otherwise advance one slot;
  // flush kills every valid bit regardless of stall.
  always_comb begin
    for (int s = 0; s <= L; s++) begin
      stage_d[s] = stage_q[s];
    end
    if (!stall) begin
      stage_d[0].valid = accept;
      stage_d[0].rem   = '0;
      stage_d[0].dvd   = bus.in_dividend;
      stage_d[0].quo   = '0;
      stage_d[0].dvs   = bus.in_divisor;
      stage_d[0].tag   = bus.in_tag;
      stage_d[0].dz    = (bus.in_divisor == '0);
      for (int s = 1; s <= L; s++) begin
        stage_d[s] = div_step(stage_q[s-1]);
      end
    end
    if (bus.flush) begin
      for (int s = 0; s <= L; s++) begin
        stage_d[s].valid = 1'b0;
      end
    end
  end

  // Pipeline registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= L; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s <= L; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  // Result fields are forced to zero whenever no result is presented
  assign bus.out_valid     = stage_q[L].valid;
  assign bus.out_quotient  = stage_q[L].valid ? stage_q[L].quo        : '0;
  assign bus.out_remainder = stage_q[L].valid ? stage_q[L].rem[M-1:0] : '0;
  assign bus.out_tag       = stage_q[L].valid ? stage_q[L].tag        : '0;
  assign bus.out_dz        = stage_q[L].valid & stage_q[L].dz;

endmodule
`default_nettype wire
